layer3_fetch: RTL and testbench

LAYER3_FETCH -- requirements
Module: layer3_fetch

---
 rtl/layer3_fetch.sv | 135 +++++++++++++
 tb/tb_layer3_fetch.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/layer3_fetch.sv
// Layer-3 activation fetcher: streams every layer-2 temp-buffer entry, in index order,
// to the layer-3 PU through a 2-entry skid FIFO, then clears the buffer.
module layer3_fetch #(
   parameter int DEPTH      = 64,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   output logic                  temp_rd_en_o,
   output logic [5:0]            temp_rd_addr_o,
   input  logic [DATA_WIDTH-1:0] temp_data_i,
   output logic                  temp_clear_o,
   output logic [DATA_WIDTH-1:0] x_o,
   output logic [5:0]            x_idx_o,
   output logic                  x_valid_o,
   input  logic                  x_ready_i,
   output logic                  x_last_o,
   output logic                  busy_o,
   output logic                  done_o
);

   localparam int AW = 6;
   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      FINISH = 2'd2
   } state_t;

   state_t                state_r;
   logic [AW-1:0]         rd_cnt_r;
   logic                  rd_all_r;
   logic                  inflight_r;
   logic [AW-1:0]         pend_idx_r;
   logic [DATA_WIDTH-1:0] fifo_data_r [2];
   logic [AW-1:0]         fifo_idx_r  [2];
   logic                  head_r;
   logic [1:0]            count_r;
   logic                  busy_r;
   logic                  done_r;

   logic                  pop_s;
   logic                  tail_s;
   logic [2:0]            occ_s;
   logic                  rd_en_s;

   // Read issue: never let FIFO entries plus the read in flight exceed two slots.
   always_comb begin
      pop_s  = (count_r != 2'd0) && x_ready_i;
      tail_s = head_r ^ count_r[0];
      occ_s  = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
      if ((state_r == READ) && !rd_all_r && (occ_s < 3'd2)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   assign temp_rd_en_o   = rd_en_s;
   assign temp_rd_addr_o = rd_cnt_r;
   assign temp_clear_o   = done_r;
   assign done_o         = done_r;
   assign busy_o         = busy_r;
   assign x_valid_o      = (count_r != 2'd0);
   assign x_o            = fifo_data_r[head_r];
   assign x_idx_o        = fifo_idx_r[head_r];
   assign x_last_o       = x_valid_o && (x_idx_o == LAST_IDX);

   // Control FSM, read counter, in-flight tracking and FIFO storage.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r    <= IDLE;
         rd_cnt_r   <= {AW{1'b0}};
         rd_all_r   <= 1'b0;
         inflight_r <= 1'b0;
         pend_idx_r <= {AW{1'b0}};
         head_r     <= 1'b0;
         count_r    <= 2'd0;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            fifo_data_r[i] <= {DATA_WIDTH{1'b0}};
            fifo_idx_r[i]  <= {AW{1'b0}};
         end
      end else begin
         // Buffer data returns one cycle after the read; its index travels alongside.
         inflight_r <= rd_en_s;
         if (rd_en_s) begin
            pend_idx_r <= rd_cnt_r;
            if (rd_cnt_r == LAST_IDX) begin
               rd_all_r <= 1'b1;
            end else begin
               rd_cnt_r <= rd_cnt_r + 6'd1;
            end
         end
         if (inflight_r) begin
            fifo_data_r[tail_s] <= temp_data_i;
            fifo_idx_r[tail_s]  <= pend_idx_r;
         end
         head_r  <= head_r ^ pop_s;
         count_r <= count_r + {1'b0, inflight_r} - {1'b0, pop_s};

         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start_i) begin
                  state_r  <= READ;
                  busy_r   <= 1'b1;
                  rd_cnt_r <= {AW{1'b0}};
                  rd_all_r <= 1'b0;
               end
            end
            READ: begin
               if (pop_s && x_last_o) begin
                  state_r <= FINISH;
                  done_r  <= 1'b1;
               end
            end
            FINISH: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_layer3_fetch.sv
// Bench for layer3_fetch: transaction-count model checked every cycle, plus literal
// timing expectations for the directed scenarios.
module tb_layer3_fetch;

   localparam int DEPTH = 64;
   localparam int DW    = 8;

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          start_i = 1'b0;
   logic          temp_rd_en_o;
   logic [5:0]    temp_rd_addr_o;
   logic [DW-1:0] temp_data_i = 8'h00;
   logic          temp_clear_o;
   logic [DW-1:0] x_o;
   logic [5:0]    x_idx_o;
   logic          x_valid_o;
   logic          x_ready_i = 1'b0;
   logic          x_last_o;
   logic          busy_o;
   logic          done_o;

   always #5 clk = ~clk;

   layer3_fetch #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .temp_rd_en_o(temp_rd_en_o), .temp_rd_addr_o(temp_rd_addr_o),
      .temp_data_i(temp_data_i), .temp_clear_o(temp_clear_o),
      .x_o(x_o), .x_idx_o(x_idx_o), .x_valid_o(x_valid_o),
      .x_ready_i(x_ready_i), .x_last_o(x_last_o),
      .busy_o(busy_o), .done_o(done_o)
   );

   // Layer-2 temp buffer model: entry k holds k+1; junk when not being read.
   logic [DW-1:0] mem [DEPTH];
   initial for (int k = 0; k < DEPTH; k++) mem[k] = DW'(k + 1);
   always @(posedge clk) temp_data_i <= temp_rd_en_o ? mem[temp_rd_addr_o] : 8'hEE;

   int checks = 0;
   int errors = 0;

   // Model: a pass is just counts of reads issued, data arrived and items transferred.
   bit m_known = 0, m_busy = 0, m_fin = 0, m_inflight = 0, m_after_rst = 0;
   int m_issued = 0, m_arrived = 0, m_xfer = 0;
   bit exp_rd = 0, exp_pop = 0, exp_valid = 0, want_first = 0;
   bit p_known = 0, p_valid = 0, p_ready = 0, p_rd = 0;
   logic [DW-1:0] p_x;
   logic [5:0] p_idx, p_addr;

   int fv[4], lc[4], dc[4];
   int nfv, nlc, ndc, xfers, stall_reads, idx32, busy78;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare(input int t);
      int occ;
      exp_rd = 0; exp_pop = 0; exp_valid = 0;
      if (m_known) begin
         if (m_after_rst) begin
            check("rst_x", x_o, 0);
            check("rst_idx", x_idx_o, 0);
            check("rst_addr", temp_rd_addr_o, 0);
         end
         check("busy", busy_o, m_busy);
         check("done", done_o, m_fin);
         check("clear", temp_clear_o, m_fin);
         exp_valid = m_busy && !m_fin && (m_arrived > m_xfer);
         check("x_valid", x_valid_o, exp_valid);
         exp_pop = exp_valid && x_ready_i;
         occ = m_issued - m_xfer - (exp_pop ? 1 : 0);
         exp_rd = m_busy && !m_fin && (m_issued < DEPTH) && (occ < 2);
         check("rd_en", temp_rd_en_o, exp_rd);
         if (exp_rd) check("rd_addr", temp_rd_addr_o, m_issued);
         else if (p_known && !p_rd && !m_after_rst) check("addr_hold", temp_rd_addr_o, p_addr);
         if (exp_valid) begin
            check("x_idx", x_idx_o, m_xfer);
            check("x_data", x_o, m_xfer + 1);
            check("x_last", x_last_o, (m_xfer == DEPTH - 1));
            if (p_valid && !p_ready) begin
               check("stall_x", x_o, p_x);
               check("stall_idx", x_idx_o, p_idx);
            end
            if (want_first) begin
               if (nfv < 4) fv[nfv] = t;
               nfv++;
               want_first = 0;
            end
         end else begin
            check("x_last_idle", x_last_o, 0);
         end
         if (exp_pop && m_xfer == DEPTH - 1) begin
            if (nlc < 4) lc[nlc] = t;
            nlc++;
         end
         if (exp_pop) xfers++;
      end
      if (done_o === 1'b1) begin
         if (ndc < 4) dc[ndc] = t;
         ndc++;
      end
      if (t >= 11 && t <= 30 && temp_rd_en_o === 1'b1) stall_reads++;
      if (t == 32) idx32 = x_valid_o ? int'(x_idx_o) : -1;
      if (t == 78) busy78 = int'(busy_o);
   endtask

   task automatic model_update();
      p_known = m_known; p_valid = x_valid_o; p_ready = x_ready_i; p_rd = temp_rd_en_o;
      p_x = x_o; p_idx = x_idx_o; p_addr = temp_rd_addr_o;
      if (rst_i) begin
         m_known = 1; m_busy = 0; m_fin = 0; m_inflight = 0; m_after_rst = 1;
         m_issued = 0; m_arrived = 0; m_xfer = 0; want_first = 0;
      end else begin
         m_after_rst = 0;
         if (!m_busy) begin
            if (start_i) begin
               m_busy = 1; m_issued = 0; m_arrived = 0; m_xfer = 0; m_inflight = 0;
               want_first = 1;
            end
         end else if (m_fin) begin
            m_busy = 0; m_fin = 0;
         end else begin
            m_arrived += m_inflight ? 1 : 0;
            m_inflight = exp_rd;
            m_issued += exp_rd ? 1 : 0;
            if (exp_pop) begin
               if (m_xfer == DEPTH - 1) m_fin = 1;
               m_xfer++;
            end
         end
      end
   endtask

   // mode 0: ready always; 1: ready pattern 1,0,0,1; 2: ready low for 20 cycles after start at 10
   task automatic run(input int len, input int mode, input int s1, input int s2,
                      input int s3, input int rst_at);
      nfv = 0; nlc = 0; ndc = 0; xfers = 0; stall_reads = 0; idx32 = -2; busy78 = -1;
      for (int t = 0; t < len; t++) begin
         @(negedge clk);
         start_i = (t == s1) || (t == s2) || (t == s3);
         rst_i   = (t == 0) || (t == rst_at);
         case (mode)
            1:       x_ready_i = ((t % 4) == 0) || ((t % 4) == 3);
            2:       x_ready_i = !(t >= 11 && t <= 30);
            default: x_ready_i = 1'b1;
         endcase
         #1;
         compare(t);
         model_update();
         @(posedge clk);
      end
   endtask

   initial begin
      // Full-speed pass
      run(90, 0, 10, -1, -1, -1);
      check("t1_first_valid", fv[0], 13);
      check("t1_last", lc[0], 76);
      check("t1_done", dc[0], 77);
      check("t1_done_cnt", ndc, 1);
      check("t1_busy78", busy78, 0);
      check("t1_xfers", xfers, 64);

      // Toggling backpressure
      run(250, 1, 10, -1, -1, -1);
      check("t2_xfers", xfers, 64);
      check("t2_done_cnt", ndc, 1);

      // Long stall right after start
      run(120, 2, 10, -1, -1, -1);
      check("t3_stall_reads", stall_reads, 2);
      check("t3_idx32", idx32, 1);
      check("t3_done", dc[0], 95);
      check("t3_xfers", xfers, 64);

      // Restart attempts while busy and during the finish cycle
      run(100, 0, 10, 20, 77, -1);
      check("t4_done_cnt", ndc, 1);
      check("t4_done", dc[0], 77);
      check("t4_xfers", xfers, 64);

      // Reset mid-pass (with a coincident start), then a fresh pass
      run(130, 0, 10, 50, 40, 40);
      check("t5_done_cnt", ndc, 1);
      check("t5_first_valid2", fv[1], 53);
      check("t5_last", lc[0], 116);
      check("t5_done", dc[0], 117);

      // Back-to-back passes
      run(160, 0, 10, 78, -1, -1);
      check("t6_done_cnt", ndc, 2);
      check("t6_done1", dc[0], 77);
      check("t6_done2", dc[1], 145);
      check("t6_first_valid2", fv[1], 81);
      check("t6_last2", lc[1], 144);
      check("t6_xfers", xfers, 128);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
